// File: rtl/pic_irr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pic_irr_gen                                                |
// | Description : PIC interrupt request register. Synchronises NUM_IRQ async |
// |               request lines, latches them in edge or level mode, clears  |
// |               on acknowledge, and flags requests lost while pending.     |
// |               Optional input glitch filter: PIC_IRR_GLITCH_FILTER_EN     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pic_irr_gen #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] ir,
  input  logic               ltim,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
  output logic [NUM_IRQ-1:0] irr,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] lost
);

  // Synchroniser chain: stage 0 samples ir, last stage is the clean level.
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] w_s_raw;
  logic [NUM_IRQ-1:0] w_s_use;

  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] lost_q, lost_d;
  logic               int_req_q, int_req_d;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_ack_hit;

  // Shift the synchroniser chain by one stage each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ir};
  end

  assign w_s_raw = sync_q[SYNC_STAGES-1];

`ifdef PIC_IRR_GLITCH_FILTER_EN
  logic [NUM_IRQ-1:0] s_hold_q, s_hold_d;
  logic [NUM_IRQ-1:0] filt_q, filt_d;

  // Filtered level follows the synchroniser only once it has matched its
  // previous-cycle value; the filtered value is used combinationally so the
  // filter costs exactly one extra edge of latency.
  always_comb begin
    s_hold_d = w_s_raw;
    filt_d   = (~(w_s_raw ^ s_hold_q) & w_s_raw) | ((w_s_raw ^ s_hold_q) & filt_q);
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_hold_q <= '0;
      filt_q   <= '0;
    end else begin
      s_hold_q <= s_hold_d;
      filt_q   <= filt_d;
    end
  end

  assign w_s_use = filt_d;
`else
  assign w_s_use = w_s_raw;
`endif

  // Request latching, acknowledge clearing and lost-request tracking.
  always_comb begin
    prev_d = w_s_use;
    w_rise = w_s_use & ~prev_q;
    // A one-hot decode truncated to NUM_IRQ bits drops out-of-range ids.
    w_ack_hit = ack_valid ? (NUM_IRQ'(1) << ack_id) : '0;
    irr_d  = irr_q;
    lost_d = lost_q;
    if (ltim) begin
      irr_d = w_s_use;
    end else begin
      // A new edge wins over a coincident acknowledge of the same channel.
      irr_d  = w_rise | (irr_q & ~w_ack_hit);
      lost_d = lost_q | (w_rise & irr_q & ~w_ack_hit);
    end
    int_req_d = |(irr_d & ~imr);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      irr_q     <= '0;
      lost_q    <= '0;
      int_req_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      irr_q     <= irr_d;
      lost_q    <= lost_d;
      int_req_q <= int_req_d;
    end
  end

  assign irr     = irr_q;
  assign lost    = lost_q;
  assign int_req = int_req_q;

endmodule
`default_nettype wire
